// File: rtl/mem_arbiter_pkg.sv
// mem_arb_pkg: types shared by the memory arbiter and its testbench.
//   arb_state_t : arbiter FSM state
//   grant_t     : which requester currently owns the RAM port
//   owner_of()  : maps a state to the owning requester
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_I    = 2'd1,
        GNT_D    = 2'd2
    } grant_t;

    function automatic grant_t owner_of(input arb_state_t s);
        case (s)
            IGNT:    return GNT_I;
            DGNT:    return GNT_D;
            default: return GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus interfaces around the memory arbiter.
//   cache_if : icache/dcache request side
//              master = caches, slave = arbiter
//   ram_if   : single RAM port
//              master = arbiter, slave = RAM model
interface cache_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic [DATA_W-1:0] iload;
    logic              iwait;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dstore;
    logic [DATA_W-1:0] dload;
    logic              dwait;

    modport master (output iREN, iaddr, dREN, dWEN, daddr, dstore,
                    input  iload, iwait, dload, dwait);
    modport slave  (input  iREN, iaddr, dREN, dWEN, daddr, dstore,
                    output iload, iwait, dload, dwait);
endinterface

interface ram_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [DATA_W-1:0] ramstore;
    logic [DATA_W-1:0] ramload;
    logic              ramack;

    modport master (output ramREN, ramWEN, ramaddr, ramstore,
                    input  ramload, ramack);
    modport slave  (input  ramREN, ramWEN, ramaddr, ramstore,
                    output ramload, ramack);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and data
// access. Data wins, but after MAX_DSTREAK consecutive data grants with a
// fetch waiting the fetch is served. A grant is held until ramack, request
// withdrawal, or watchdog expiry (sticky err).
// Ports:
//   CLK, RST : clock (rising edge), async active-high reset
//   cpu      : cache_if.slave, fetch/data requests, load data, wait flags
//   ram      : ram_if.master, RAM strobes, address, write data, ack
//   err      : sticky watchdog timeout flag
// MAX_DSTREAK must be 1..15, TIMEOUT must be 2..255.
//
//   state | meaning
//   IDLE  | no owner, arbitrate; no RAM strobes
//   IGNT  | fetch owns the RAM port
//   DGNT  | data access owns the RAM port
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic     CLK,
    input  logic     RST,
    cache_if.slave   cpu,
    ram_if.master    ram,
    output logic     err
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    arb_state_t        state, state_nxt;
    grant_t            owner;
    logic [3:0]        streak, streak_nxt;
    logic [7:0]        tmo, tmo_nxt;
    logic              err_nxt;
    logic [ADDR_W-1:0] cap_addr, cap_addr_nxt;
    logic [DATA_W-1:0] cap_store, cap_store_nxt;
    logic              cap_wen, cap_wen_nxt;

    logic dreq, i_active, d_active, i_done, d_done;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            streak    <= 4'd0;
            tmo       <= 8'd0;
            err       <= 1'b0;
            cap_addr  <= '0;
            cap_store <= '0;
            cap_wen   <= 1'b0;
        end else begin
            state     <= state_nxt;
            streak    <= streak_nxt;
            tmo       <= tmo_nxt;
            err       <= err_nxt;
            cap_addr  <= cap_addr_nxt;
            cap_store <= cap_store_nxt;
            cap_wen   <= cap_wen_nxt;
        end
    end

    // An owner that drops its request loses the port in the same cycle,
    // so strobes and completion are both gated by the live request.
    always_comb begin
        dreq     = cpu.dREN | cpu.dWEN;
        owner    = owner_of(state);
        i_active = (owner == GNT_I) && cpu.iREN;
        d_active = (owner == GNT_D) && dreq;
        i_done   = i_active && ram.ramack;
        d_done   = d_active && ram.ramack;

        ram.ramREN   = i_active | (d_active & ~cap_wen);
        ram.ramWEN   = d_active & cap_wen;
        ram.ramaddr  = (owner != GNT_NONE) ? cap_addr : '0;
        ram.ramstore = (owner == GNT_D) ? cap_store : '0;

        cpu.iload = i_done ? ram.ramload : '0;
        cpu.dload = d_done ? ram.ramload : '0;
        cpu.iwait = cpu.iREN & ~i_done;
        cpu.dwait = dreq & ~d_done;
    end

    always_comb begin
        state_nxt     = state;
        streak_nxt    = streak;
        tmo_nxt       = tmo;
        err_nxt       = err;
        cap_addr_nxt  = cap_addr;
        cap_store_nxt = cap_store;
        cap_wen_nxt   = cap_wen;

        case (state)
            IDLE: begin
                tmo_nxt = 8'd0;
                if (dreq && !(cpu.iREN && streak == STREAK_MAX)) begin
                    state_nxt     = DGNT;
                    cap_addr_nxt  = cpu.daddr;
                    cap_store_nxt = cpu.dstore;
                    // dREN together with dWEN is a write
                    cap_wen_nxt   = cpu.dWEN;
                    if (cpu.iREN && streak != STREAK_MAX)
                        streak_nxt = streak + 4'd1;
                end else if (cpu.iREN) begin
                    state_nxt    = IGNT;
                    cap_addr_nxt = cpu.iaddr;
                    cap_wen_nxt  = 1'b0;
                    streak_nxt   = 4'd0;
                end else begin
                    streak_nxt = 4'd0;
                end
            end
            IGNT, DGNT: begin
                if ((state == IGNT) ? (!i_active || i_done)
                                    : (!d_active || d_done)) begin
                    state_nxt = IDLE;
                    tmo_nxt   = 8'd0;
                end else if (tmo == TMO_LAST) begin
                    state_nxt = IDLE;
                    tmo_nxt   = 8'd0;
                    err_nxt   = 1'b1;
                end else begin
                    tmo_nxt = tmo + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a small RAM responder that acks
// LAT cycles after a strobe first appears (when ack_en is set).
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    logic err;
    int   checks = 0;
    int   failures = 0;

    localparam logic [7:0] LAT = 8'd2;
    logic       ack_en = 1'b0;
    logic [7:0] cnt = 8'd0;

    cache_if #(.ADDR_W(32), .DATA_W(32)) cbus();
    ram_if   #(.ADDR_W(32), .DATA_W(32)) rbus();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4), .TIMEOUT(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .cpu (cbus),
        .ram (rbus),
        .err (err)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK)
        cnt <= ((rbus.ramREN || rbus.ramWEN) && !rbus.ramack) ? cnt + 8'd1 : 8'd0;

    assign rbus.ramack = ack_en && (rbus.ramREN || rbus.ramWEN) && (cnt == LAT);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        RST = 1'b1;
        cbus.iREN = 1'b0; cbus.iaddr = '0;
        cbus.dREN = 1'b0; cbus.dWEN = 1'b0; cbus.daddr = '0; cbus.dstore = '0;
        rbus.ramload = 32'hDEADBEEF;

        // reset state
        #2;
        check("rst_state", 32'(dut.state), 32'(IDLE));
        check("rst_streak", 32'(dut.streak), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_strobes", {30'd0, rbus.ramREN, rbus.ramWEN}, 32'd0);
        check("rst_ramaddr", rbus.ramaddr, 32'd0);
        check("rst_ramstore", rbus.ramstore, 32'd0);
        check("rst_loads", cbus.iload | cbus.dload, 32'd0);
        cbus.iREN = 1'b1; cbus.dWEN = 1'b1;
        #1;
        check("rst_iwait", 32'(cbus.iwait), 32'd1);
        check("rst_dwait", 32'(cbus.dwait), 32'd1);
        cbus.iREN = 1'b0; cbus.dWEN = 1'b0;
        #9;
        RST = 1'b0;   // t=12, cycle 0, IDLE

        // fetch only
        ack_en = 1'b1;
        cbus.iREN = 1'b1; cbus.iaddr = 32'h100;
        #1;
        check("f_c0_noren", 32'(rbus.ramREN), 32'd0);
        step();                                        // cycle 1
        check("f_c1_ren", 32'(rbus.ramREN), 32'd1);
        check("f_c1_addr", rbus.ramaddr, 32'h100);
        check("f_c1_iwait", 32'(cbus.iwait), 32'd1);
        check("f_c1_iload", cbus.iload, 32'd0);
        step();                                        // cycle 2
        check("f_c2_noack", 32'(rbus.ramack), 32'd0);
        step();                                        // cycle 3
        check("f_c3_ack", 32'(rbus.ramack), 32'd1);
        check("f_c3_iwait", 32'(cbus.iwait), 32'd0);
        check("f_c3_iload", cbus.iload, 32'hDEADBEEF);
        step();                                        // cycle 4
        check("f_c4_idle", 32'(dut.state), 32'(IDLE));
        check("f_c4_noren", 32'(rbus.ramREN), 32'd0);

        // simultaneous fetch + data write
        cbus.dWEN = 1'b1; cbus.daddr = 32'h200; cbus.dstore = 32'h1234;
        rbus.ramload = 32'h0BADF00D;
        step();                                        // cycle 5, DGNT
        check("s_dgnt_wen", 32'(rbus.ramWEN), 32'd1);
        check("s_dgnt_ren", 32'(rbus.ramREN), 32'd0);
        check("s_dgnt_addr", rbus.ramaddr, 32'h200);
        check("s_dgnt_store", rbus.ramstore, 32'h1234);
        check("s_dgnt_iwait", 32'(cbus.iwait), 32'd1);
        step();
        step();                                        // cycle 7, ack
        check("s_dack_dwait", 32'(cbus.dwait), 32'd0);
        check("s_dack_dload", cbus.dload, 32'h0BADF00D);
        check("s_dack_iwait", 32'(cbus.iwait), 32'd1);
        step();                                        // cycle 8, IDLE
        cbus.dWEN = 1'b0;
        check("s_idle_state", 32'(dut.state), 32'(IDLE));
        check("s_idle_strobes", {30'd0, rbus.ramREN, rbus.ramWEN}, 32'd0);
        step();                                        // cycle 9, IGNT
        check("s_ignt_ren", 32'(rbus.ramREN), 32'd1);
        check("s_ignt_addr", rbus.ramaddr, 32'h100);
        step();
        step();                                        // cycle 11, ack
        check("s_iack_iload", cbus.iload, 32'h0BADF00D);
        step();                                        // cycle 12, IDLE

        // starvation bound: 4 data grants, 1 fetch, data again
        cbus.dREN = 1'b1; cbus.daddr = 32'h300;
        for (int g = 0; g < 4; g++) begin
            step();
            check($sformatf("st_d%0d_ren", g), 32'(rbus.ramREN), 32'd1);
            check($sformatf("st_d%0d_addr", g), rbus.ramaddr, 32'h300);
            step();
            step();
            check($sformatf("st_d%0d_ack", g), 32'(cbus.dwait), 32'd0);
            step();
            check($sformatf("st_d%0d_idle", g), 32'(rbus.ramREN), 32'd0);
        end
        check("st_streak_sat", 32'(dut.streak), 32'd4);
        step();
        check("st_i_addr", rbus.ramaddr, 32'h100);
        check("st_i_dwait", 32'(cbus.dwait), 32'd1);
        step();
        step();
        check("st_i_ack", 32'(cbus.iwait), 32'd0);
        step();
        step();
        check("st_resume_addr", rbus.ramaddr, 32'h300);
        check("st_resume_ren", 32'(rbus.ramREN), 32'd1);

        // withdrawal in DGNT
        cbus.dREN = 1'b0;
        #1;
        check("w_strobe_drop", {30'd0, rbus.ramREN, rbus.ramWEN}, 32'd0);
        check("w_dwait", 32'(cbus.dwait), 32'd0);
        ack_en = 1'b0;
        step();
        check("w_idle", 32'(dut.state), 32'(IDLE));
        check("w_err", 32'(err), 32'd0);

        // timeout on the pending fetch
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("t_ignt%0d_ren", k), 32'(rbus.ramREN), 32'd1);
            check($sformatf("t_ignt%0d_err", k), 32'(err), 32'd0);
        end
        step();
        check("t_err_set", 32'(err), 32'd1);
        check("t_after_ren", 32'(rbus.ramREN), 32'd0);
        check("t_iwait", 32'(cbus.iwait), 32'd1);
        cbus.iREN = 1'b0;
        step();
        check("t_err_sticky", 32'(err), 32'd1);
        ack_en = 1'b1;

        // reset mid-access
        cbus.iREN = 1'b1; cbus.dWEN = 1'b1; cbus.daddr = 32'h400;
        step();
        check("r_dgnt_wen", 32'(rbus.ramWEN), 32'd1);
        check("r_streak", 32'(dut.streak), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("r_async_strobes", {30'd0, rbus.ramREN, rbus.ramWEN}, 32'd0);
        check("r_err_clr", 32'(err), 32'd0);
        check("r_dwait", 32'(cbus.dwait), 32'd1);
        step();
        RST = 1'b0;
        #1;
        check("r_state", 32'(dut.state), 32'(IDLE));
        check("r_streak0", 32'(dut.streak), 32'd0);
        cbus.iREN = 1'b0; cbus.dWEN = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
